irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Machine-level interrupt controller sitting between the external interrupt pins and the CSR unit.
//  - Synchronises and latches N_IRQ request lines.
//  - Masks them with an enable register and picks one winner by fixed priority.
//  - Drives the CSR external-interrupt input with a req/ack/done handshake; ack = interrupt taken, done = mret/epc taken.
//  - Optionally hosts the machine timer that drives the CSR timer-interrupt input.
// PARAMETERS
//  N_IRQ          4        number of external interrupt lines (2..16)
//  SYNC_STAGES    2        flops in each input synchroniser (>=2)
//  EDGE_MASK      '1       bit i=1: line i is rising-edge triggered; 0: level triggered
//  TIMER_PRESCALE 1        mtime increments once every TIMER_PRESCALE clk cycles (>=1)
// PORTS
//  clk        in   1              core clock
//  rst        in   1              asynchronous reset, active-low
//  irq_in     in   N_IRQ          raw asynchronous interrupt requests
//  ext_irq_o  out  1              to CSR external_inter; high while request outstanding
//  irq_id_o   out  $clog2(N_IRQ)  index of the line being presented/serviced
//  irq_ack_i  in   1              1-cycle pulse: core took the interrupt
//  irq_done_i in   1              1-cycle pulse: handler returned (mret)
//  timer_irq_o out 1              to CSR timer_inter
//  cfg_we     in   1              config write strobe
//  cfg_addr   in   2              0=ENABLE 1=PENDING 2=MTIMECMP 3=MTIME
//  cfg_wdata  in   32             config write data
//  cfg_rdata  out  32             config read data, combinational from cfg_addr
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; enable, pending, irq_id_o, ext_irq_o, timer_irq_o = 0.
//  Reset (cont.): mtime=0; mtimecmp=32'hFFFF_FFFF; synchronisers cleared. Reset mid-handshake aborts it silently.
//  Input path:
//  - Each irq_in bit passes through SYNC_STAGES flops.
//  - Edge line: pending[i] set on a 0->1 transition of the synchronised value; cleared on ack (winner only) or cfg W1C.
//  - Level line: pending[i] follows the synchronised value; ack and W1C have no effect on it.
//  - Set beats clear: a new edge on line i in the same cycle as its clear leaves pending[i]=1.
//  Arbitration: eligible = pending & enable[N_IRQ-1:0]; lowest index wins.
//  FSM (registered outputs):
//  - IDLE: eligible!=0 -> REQ; latch winner into irq_id_o; ext_irq_o<=1.
//  - REQ, irq_ack_i=1 -> SERVICE; ext_irq_o<=0; clear pending[irq_id_o] if edge line.
//  - REQ, eligible[irq_id_o]=0 and no ack -> IDLE; ext_irq_o<=0. Request withdrawn; no re-arbitration in this cycle.
//  - REQ, otherwise: hold; winner does not change even if a higher-priority line arrives.
//  - SERVICE, irq_done_i=1 -> IDLE; irq_id_o holds until next win. No nesting.
//  - Ack is ignored outside REQ; done is ignored outside SERVICE. Ack and done together in REQ: ack only.
//  Latency: irq_in high before clk edge k (k=1 is the first sampling edge).
//  - Edge line, SYNC_STAGES=2: pending=1 after edge 3; ext_irq_o=1 after edge 4.
//  - Level line, SYNC_STAGES=2: pending=1 after edge 2; ext_irq_o=1 after edge 3.
//  - Back-to-back: earliest re-request is 1 cycle after done.
//  Config writes, applied on the clk edge with cfg_we=1:
//  - ENABLE: enable <= wdata[N_IRQ-1:0].
//  - PENDING: write-1-to-clear, edge lines only.
//  - Reads zero-extend; unused bits read 0.
// CONFIGURATION
//  IRQ_ARBITER_MTIMER_EN defined:
//  - mtime is a 32-bit up-counter advancing every TIMER_PRESCALE cycles; it wraps 32'hFFFF_FFFF -> 0.
//  - timer_irq_o is registered: (mtime >= mtimecmp), unsigned.
//  - MTIME and MTIMECMP are writable.
//  - A same-cycle mtime write overrides the increment.
//  IRQ_ARBITER_MTIMER_EN undefined:
//  - No timer logic; timer_irq_o tied 0.
//  - Addresses 2 and 3 read 0 and ignore writes.
// TESTING
//  1 Reset: rst=0 mid-REQ -> ext_irq_o=0, state IDLE, cfg_rdata@ENABLE=0, @MTIMECMP=FFFF_FFFF (timer build).
//  2 Basic: ENABLE=4'b0100, pulse irq_in[2] -> ext_irq_o=1 after edge 4, irq_id_o=2.
//    Then ack -> ext_irq_o=0, PENDING=0. Then done -> IDLE.
//  3 Priority: irq_in[3] and [1] rise together, ENABLE=4'hF -> id=1 served first.
//    After done -> id=3 presented 1 cycle later.
//  4 Withdraw: level line 0 raised then dropped before ack -> ext_irq_o falls, no SERVICE entered.
//    Also: ack pulsed in IDLE -> ignored.
//  5 Set-vs-clear: new edge on line 2 in the same cycle as its ack -> PENDING reads 4'b0100 afterwards.
//    Same for the cfg W1C path.
//  6 Timer (MTIMER_EN, PRESCALE=1): MTIME=0, MTIMECMP=10 -> timer_irq_o=1 from cycle 11.
//    Write MTIMECMP=FFFF_FFFF -> timer_irq_o=0 next cycle.
//    Non-timer build: timer_irq_o stays 0.

Source files
------------

// File: rtl/irq_arbiter.sv
// ============================================================================
// Module   : irq_arbiter
// Brief    : Machine-level interrupt controller. Synchronises and latches the
//            external request lines, masks them with an enable register,
//            picks the lowest-index winner and presents it to the CSR unit
//            through a req/ack/done handshake. When IRQ_ARBITER_MTIMER_EN is
//            defined it also hosts the machine timer (mtime/mtimecmp) that
//            drives the CSR timer-interrupt input.
// Build    : define IRQ_ARBITER_MTIMER_EN to include the machine timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_arbiter #(
  parameter int                 N_IRQ          = 4,
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [N_IRQ-1:0]   EDGE_MASK      = '1,
  parameter int                 TIMER_PRESCALE = 1
) (
  input  logic                       clk,
  input  logic                       rst,          // asynchronous, active-low
  input  logic [N_IRQ-1:0]           irq_in,
  output logic                       ext_irq_o,
  output logic [$clog2(N_IRQ)-1:0]   irq_id_o,
  input  logic                       irq_ack_i,
  input  logic                       irq_done_i,
  output logic                       timer_irq_o,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_addr,
  input  logic [31:0]                cfg_wdata,
  output logic [31:0]                cfg_rdata
);

  localparam int         c_idw           = $clog2(N_IRQ);
  localparam logic [1:0] c_addr_enable   = 2'd0;
  localparam logic [1:0] c_addr_pending  = 2'd1;
  localparam logic [1:0] c_addr_mtimecmp = 2'd2;
  localparam logic [1:0] c_addr_mtime    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_d;
  logic [N_IRQ-1:0]                  synced;

  logic [N_IRQ-1:0] edge_prev_q;
  logic [N_IRQ-1:0] edge_prev_d;
  logic [N_IRQ-1:0] pend_edge_q;
  logic [N_IRQ-1:0] pend_edge_d;
  logic [N_IRQ-1:0] set_mask;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] w1c_clr;
  logic [N_IRQ-1:0] clr_mask;

  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] enable_d;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic             win_any;
  logic [c_idw-1:0] win_id;
  logic             cur_eligible;

  state_e           state_q;
  logic             ext_irq_q;
  logic [c_idw-1:0] irq_id_q;

  logic             cfg_wr_enable;
  logic             cfg_wr_pending;

  assign cfg_wr_enable  = cfg_we && (cfg_addr == c_addr_enable);
  assign cfg_wr_pending = cfg_we && (cfg_addr == c_addr_pending);

  // --------------------------------------------------------------------------
  // Input synchronisers: stage 0 samples the raw pins, the last stage is the
  // value the rest of the design sees.
  // --------------------------------------------------------------------------

  // Shift every line one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  // Synchroniser flops, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Pending latch. Only edge-triggered lines own a flop; level lines simply
  // mirror the synchronised value, so ack/W1C cannot touch them. A new edge
  // in the same cycle as a clear wins, so no request is ever lost.
  // --------------------------------------------------------------------------

  // Compute edge detection and the set/clear masks for the pending flops.
  always_comb begin
    edge_prev_d = synced;
    set_mask    = synced & ~edge_prev_q & EDGE_MASK;
    ack_clr     = '0;
    if ((state_q == S_REQ) && irq_ack_i) begin
      ack_clr = N_IRQ'(1) << irq_id_q;
    end
    w1c_clr     = cfg_wr_pending ? cfg_wdata[N_IRQ-1:0] : '0;
    clr_mask    = (ack_clr | w1c_clr) & EDGE_MASK;
    pend_edge_d = ((pend_edge_q & ~clr_mask) | set_mask) & EDGE_MASK;
  end

  // Edge history and edge-pending flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_prev_q <= '0;
      pend_edge_q <= '0;
    end else begin
      edge_prev_q <= edge_prev_d;
      pend_edge_q <= pend_edge_d;
    end
  end

  assign pending = pend_edge_q | (synced & ~EDGE_MASK);

  // --------------------------------------------------------------------------
  // Enable register
  // --------------------------------------------------------------------------

  // Next enable value: replaced wholesale on a write to ENABLE.
  always_comb begin
    enable_d = enable_q;
    if (cfg_wr_enable) begin
      enable_d = cfg_wdata[N_IRQ-1:0];
    end
  end

  // Enable flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q <= '0;
    end else begin
      enable_q <= enable_d;
    end
  end

  // --------------------------------------------------------------------------
  // Fixed-priority arbitration: lowest eligible index wins.
  // --------------------------------------------------------------------------

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    eligible = pending & enable_q;
    win_any  = |eligible;
    win_id   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = c_idw'(i);
      end
    end
  end

  // Whether the line currently latched as winner is still requesting.
  assign cur_eligible = eligible[irq_id_q];

  // --------------------------------------------------------------------------
  // Handshake FSM. The winner is frozen once presented; a higher-priority
  // arrival waits until the current request is taken or withdrawn. A
  // withdrawal drops straight to IDLE and re-arbitrates on the next cycle.
  // --------------------------------------------------------------------------

  // Request/acknowledge/done sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ext_irq_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            state_q   <= S_REQ;
            irq_id_q  <= win_id;
            ext_irq_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (irq_ack_i) begin
            state_q   <= S_SERVICE;
            ext_irq_q <= 1'b0;
          end else if (!cur_eligible) begin
            state_q   <= S_IDLE;
            ext_irq_q <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (irq_done_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ext_irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign ext_irq_o = ext_irq_q;
  assign irq_id_o  = irq_id_q;

`ifdef IRQ_ARBITER_MTIMER_EN
  // --------------------------------------------------------------------------
  // Machine timer
  // --------------------------------------------------------------------------
  logic [31:0] mtime_q;
  logic [31:0] mtime_d;
  logic [31:0] mtimecmp_q;
  logic [31:0] mtimecmp_d;
  logic        timer_irq_q;
  logic        timer_irq_d;
  logic        mtime_tick;

  if (TIMER_PRESCALE > 1) begin : g_prescale
    localparam int         c_pw   = $clog2(TIMER_PRESCALE);
    localparam logic [c_pw-1:0] c_last = c_pw'(TIMER_PRESCALE - 1);

    logic [c_pw-1:0] presc_q;
    logic [c_pw-1:0] presc_d;

    // Free-running divider; mtime advances on its terminal count.
    always_comb begin
      presc_d = (presc_q == c_last) ? '0 : presc_q + 1'b1;
    end

    // Divider flops.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_d;
      end
    end

    assign mtime_tick = (presc_q == c_last);
  end else begin : g_no_prescale
    assign mtime_tick = 1'b1;
  end

  // Next timer state: a software write to mtime takes precedence over the
  // increment; the compare is taken on the current registered values.
  always_comb begin
    mtime_d = mtime_q;
    if (cfg_we && (cfg_addr == c_addr_mtime)) begin
      mtime_d = cfg_wdata;
    end else if (mtime_tick) begin
      mtime_d = mtime_q + 32'd1;
    end
    mtimecmp_d = mtimecmp_q;
    if (cfg_we && (cfg_addr == c_addr_mtimecmp)) begin
      mtimecmp_d = cfg_wdata;
    end
    timer_irq_d = (mtime_q >= mtimecmp_q);
  end

  // Timer flops; mtimecmp resets to all-ones so no interrupt fires at start-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign timer_irq_o = timer_irq_q;
`else
  // No timer: the CSR timer input is held low and addresses 2/3 are inert.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, cfg_wdata[31:N_IRQ]};
  assign timer_irq_o  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Configuration read mux (combinational, zero-extended).
  // --------------------------------------------------------------------------

  // Select the register addressed by cfg_addr.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      c_addr_enable:   cfg_rdata[N_IRQ-1:0] = enable_q;
      c_addr_pending:  cfg_rdata[N_IRQ-1:0] = pending;
`ifdef IRQ_ARBITER_MTIMER_EN
      c_addr_mtimecmp: cfg_rdata = mtimecmp_q;
      c_addr_mtime:    cfg_rdata = mtime_q;
`endif
      default:         cfg_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// Module   : tb_irq_arbiter
// Brief    : Self-checking bench for irq_arbiter. Line 0 is level triggered,
//            lines 1..3 are edge triggered. Expected winner ids are queued
//            when stimulus is issued and popped by a monitor whenever the DUT
//            raises ext_irq_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_in = '0;
  logic        ext_irq_o;
  logic [1:0]  irq_id_o;
  logic        irq_ack_i = 1'b0;
  logic        irq_done_i = 1'b0;
  logic        timer_irq_o;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic ext_prev = 1'b0;

  always #5 clk = ~clk;

  irq_arbiter #(
    .N_IRQ          (4),
    .SYNC_STAGES    (2),
    .EDGE_MASK      (4'b1110),
    .TIMER_PRESCALE (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .ext_irq_o   (ext_irq_o),
    .irq_id_o    (irq_id_o),
    .irq_ack_i   (irq_ack_i),
    .irq_done_i  (irq_done_i),
    .timer_irq_o (timer_irq_o),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each new request must match the oldest expected id.
  always @(negedge clk) begin
    if (rst && ext_irq_o && !ext_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got request id %0d expected none", irq_id_o);
      end else begin
        chk("sb_id", 32'(irq_id_o), 32'(exp_q.pop_front()));
      end
    end
    ext_prev <= ext_irq_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_ack();
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done_i = 1'b1;
    tick(1);
    irq_done_i = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 30; i++) begin
      if (ext_irq_o) break;
      tick(1);
    end
    chk(name, 32'(ext_irq_o), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  en;
    logic [3:0]  pl;
    int          nserve;

    // ---------------- Reset values and reset mid-request ----------------
    tick(3);
    chk("rst_ext", 32'(ext_irq_o), 32'd0);
    chk("rst_timer", 32'(timer_irq_o), 32'd0);
    cfg_read(2'd0, d); chk("rst_enable", d, 32'd0);
`ifdef IRQ_ARBITER_MTIMER_EN
    cfg_read(2'd2, d); chk("rst_mtimecmp", d, 32'hFFFF_FFFF);
`endif
    tick(1);
    rst = 1'b1;
    tick(1);
    cfg_write(2'd0, 32'h2);
    exp_q.push_back(1);
    irq_in[1] = 1'b1;
    wait_req("t1_req");
    tick(1);
    chk("t1_hold", 32'(ext_irq_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_reset_ext", 32'(ext_irq_o), 32'd0);
    irq_in = '0;
    tick(3);
    rst = 1'b1;
    cfg_read(2'd0, d); chk("t1_enable_cleared", d, 32'd0);
    cfg_read(2'd1, d); chk("t1_pending_cleared", d, 32'd0);
    tick(6);
    chk("t1_idle_after_reset", 32'(ext_irq_o), 32'd0);

    // ---------------- Basic edge latency ----------------
    cfg_write(2'd0, 32'h4);
    exp_q.push_back(2);
    irq_in[2] = 1'b1;
    tick(3);
    cfg_read(2'd1, d); chk("t2_pending_edge3", d, 32'h4);
    chk("t2_ext_not_yet", 32'(ext_irq_o), 32'd0);
    tick(1);
    chk("t2_ext_edge4", 32'(ext_irq_o), 32'd1);
    chk("t2_id", 32'(irq_id_o), 32'd2);
    irq_in[2] = 1'b0;
    tick(2);
    pulse_ack();
    chk("t2_ext_after_ack", 32'(ext_irq_o), 32'd0);
    cfg_read(2'd1, d); chk("t2_pending_after_ack", d, 32'd0);
    pulse_done();
    tick(3);
    chk("t2_idle", 32'(ext_irq_o), 32'd0);

    // ---------------- Priority and back-to-back ----------------
    cfg_write(2'd0, 32'hF);
    exp_q.push_back(1);
    exp_q.push_back(3);
    irq_in = 4'b1010;
    tick(2);
    irq_in = '0;
    wait_req("t3_req1");
    chk("t3_first_id", 32'(irq_id_o), 32'd1);
    tick(2);
    pulse_ack();
    tick(1);
    pulse_done();
    chk("t3_gap", 32'(ext_irq_o), 32'd0);
    tick(1);
    chk("t3_second_ext", 32'(ext_irq_o), 32'd1);
    chk("t3_second_id", 32'(irq_id_o), 32'd3);
    pulse_ack();
    pulse_done();

    // ---------------- Level line withdraw, ack in IDLE ----------------
    cfg_write(2'd0, 32'h1);
    exp_q.push_back(0);
    irq_in[0] = 1'b1;
    tick(2);
    cfg_read(2'd1, d); chk("t4_level_pending", d, 32'h1);
    chk("t4_level_ext_early", 32'(ext_irq_o), 32'd0);
    tick(1);
    chk("t4_level_ext", 32'(ext_irq_o), 32'd1);
    chk("t4_level_id", 32'(irq_id_o), 32'd0);
    irq_in[0] = 1'b0;
    tick(4);
    chk("t4_withdrawn", 32'(ext_irq_o), 32'd0);
    pulse_ack();
    tick(2);
    cfg_write(2'd0, 32'h4);
    exp_q.push_back(2);
    irq_in[2] = 1'b1;
    tick(2);
    irq_in[2] = 1'b0;
    wait_req("t4_req_after_idle_ack");
    tick(1);
    pulse_ack();
    pulse_done();

    // ---------------- Set beats clear: ack path ----------------
    tick(4);
    exp_q.push_back(2);
    irq_in[2] = 1'b1;
    tick(2);
    irq_in[2] = 1'b0;
    wait_req("t5_req");
    tick(2);
    irq_in[2] = 1'b1;
    tick(2);
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
    irq_in[2] = 1'b0;
    cfg_read(2'd1, d); chk("t5_ack_set_wins", d, 32'h4);
    chk("t5_in_service", 32'(ext_irq_o), 32'd0);
    exp_q.push_back(2);
    pulse_done();
    wait_req("t5_rereq");
    tick(1);
    pulse_ack();
    pulse_done();
    cfg_read(2'd1, d); chk("t5_pending_drained", d, 32'd0);

    // ---------------- Set beats clear: W1C path ----------------
    cfg_write(2'd0, 32'h0);
    irq_in[2] = 1'b1;
    tick(2);
    irq_in[2] = 1'b0;
    tick(4);
    cfg_read(2'd1, d); chk("t5_w1c_pre", d, 32'h4);
    irq_in[2] = 1'b1;
    tick(2);
    cfg_write(2'd1, 32'h4);
    cfg_read(2'd1, d); chk("t5_w1c_set_wins", d, 32'h4);
    irq_in[2] = 1'b0;
    tick(4);
    cfg_write(2'd1, 32'h4);
    cfg_read(2'd1, d); chk("t5_w1c_clear", d, 32'h0);
    irq_in[0] = 1'b1;
    tick(3);
    cfg_write(2'd1, 32'h1);
    cfg_read(2'd1, d); chk("t5_level_ignores_w1c", d, 32'h1);
    irq_in[0] = 1'b0;
    tick(3);

    // ---------------- Timer ----------------
`ifdef IRQ_ARBITER_MTIMER_EN
    cfg_write(2'd2, 32'd10);
    cfg_write(2'd3, 32'd0);
    tick(10);
    chk("t6_timer_before", 32'(timer_irq_o), 32'd0);
    tick(1);
    chk("t6_timer_fires", 32'(timer_irq_o), 32'd1);
    cfg_read(2'd3, d); chk("t6_mtime_count", d, 32'd11);
    cfg_write(2'd2, 32'hFFFF_FFFF);
    tick(1);
    chk("t6_timer_cleared", 32'(timer_irq_o), 32'd0);
    cfg_write(2'd3, 32'hFFFF_FFFE);
    tick(1);
    cfg_read(2'd3, d); chk("t6_mtime_max", d, 32'hFFFF_FFFF);
    tick(1);
    cfg_read(2'd3, d); chk("t6_mtime_wrap", d, 32'd0);
    chk("t6_timer_at_max", 32'(timer_irq_o), 32'd1);
    tick(1);
    chk("t6_timer_after_wrap", 32'(timer_irq_o), 32'd0);
`else
    cfg_write(2'd3, 32'd5);
    cfg_read(2'd3, d); chk("t6_no_mtime", d, 32'd0);
    cfg_write(2'd2, 32'd0);
    tick(3);
    chk("t6_no_timer", 32'(timer_irq_o), 32'd0);
`endif

    // ---------------- Randomised bursts on edge lines ----------------
    for (int it = 0; it < 20; it++) begin
      en = 4'($urandom);
      pl = 4'($urandom_range(1, 7)) << 1;
      cfg_write(2'd0, 32'(en));
      nserve = 0;
      for (int i = 0; i < 4; i++) begin
        if (pl[i] && en[i]) begin
          exp_q.push_back(i);
          nserve++;
        end
      end
      irq_in = pl;
      tick(2);
      irq_in = '0;
      for (int k = 0; k < nserve; k++) begin
        wait_req("rnd_req");
        tick($urandom_range(0, 3));
        pulse_ack();
        tick($urandom_range(0, 3));
        pulse_done();
      end
      tick(5);
      chk("rnd_quiet", 32'(ext_irq_o), 32'd0);
      cfg_read(2'd1, d); chk("rnd_leftover", d, 32'(pl & ~en));
      cfg_write(2'd1, 32'hF);
    end

    tick(5);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
